// File: rtl/decode_stage.sv
// decode_stage: one-entry decode pipeline register with an integrated
// register file. An accepted instruction is decoded and its operands are read
// in the cycle it is accepted. The bundle appears on the outputs one edge later
// and holds while the consumer stalls.
//
// Optional feature: define DECODE_BYPASS_EN so that an operand read returns
// the write data when it hits a writeback in the same cycle. Without the
// macro, such a read returns the value the register held before the write.
//
// Handshake: both ports use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. On the input side, in_ready equals
// !out_valid || out_ready, so a new instruction can enter the same cycle the
// held bundle leaves. On the output side, the bundle and out_valid stay stable
// while out_valid=1 and out_ready=0.

module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [8:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        opcode,
    output logic [8:0]        rd,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] rt_val,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    localparam int REG_W = $clog2(NUM_REGS);

    // True when a 9-bit register index names a register that exists.
    function automatic logic idx_ok(input logic [8:0] idx);
        return ({23'd0, idx} < NUM_REGS);
    endfunction

    // Instruction fields
    logic [4:0] f_op;
    logic [8:0] f_rd;
    logic [8:0] f_rs;
    logic [8:0] f_rt;

    assign f_op = instr[31:27];
    assign f_rd = instr[26:18];
    assign f_rs = instr[17:9];
    assign f_rt = instr[8:0];

    // Register file
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wb_ok;

    assign wb_ok = wb_en && idx_ok(wb_addr);

    // Next register-file contents: apply an in-range writeback, drop the rest.
    always_comb begin
        regs_d = regs_q;
        if (wb_ok) begin
            regs_d[wb_addr[REG_W-1:0]] = wb_data;
        end
    end

    // Register file storage; reset clears every entry and blocks writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand read ports
    logic              f_rd_ok;
    logic              f_rs_ok;
    logic              f_rt_ok;
    logic [DATA_W-1:0] val_rd;
    logic [DATA_W-1:0] val_rs;
    logic [DATA_W-1:0] val_rt;

    // Read the three candidate source registers. Out-of-range indices read as 0.
    always_comb begin
        f_rd_ok = idx_ok(f_rd);
        f_rs_ok = idx_ok(f_rs);
        f_rt_ok = idx_ok(f_rt);
        val_rd  = '0;
        val_rs  = '0;
        val_rt  = '0;
        if (f_rd_ok) val_rd = regs_q[f_rd[REG_W-1:0]];
        if (f_rs_ok) val_rs = regs_q[f_rs[REG_W-1:0]];
        if (f_rt_ok) val_rt = regs_q[f_rt[REG_W-1:0]];
`ifdef DECODE_BYPASS_EN
        if (f_rd_ok && wb_ok && (wb_addr == f_rd)) val_rd = wb_data;
        if (f_rs_ok && wb_ok && (wb_addr == f_rs)) val_rs = wb_data;
        if (f_rt_ok && wb_ok && (wb_addr == f_rt)) val_rt = wb_data;
`endif
    end

    // Decoded bundle of the instruction currently on the input
    logic [4:0]        dec_opcode;
    logic [8:0]        dec_rd;
    logic [DATA_W-1:0] dec_rs_val;
    logic [DATA_W-1:0] dec_rt_val;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;

    // Opcode decode. Any field an opcode does not drive stays 0.
    always_comb begin
        dec_opcode  = f_op;
        dec_rd      = '0;
        dec_rs_val  = '0;
        dec_rt_val  = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (f_op)
            5'd0: begin
                // NOP: nothing beyond the zero opcode
            end
            5'd1, 5'd6: begin
                dec_rd  = f_rd;
                dec_imm = {{(DATA_W-18){1'b0}}, instr[17:0]};
            end
            5'd2, 5'd3, 5'd4, 5'd5: begin
                dec_rd      = f_rd;
                dec_rs_val  = val_rs;
                dec_rt_val  = val_rt;
                dec_illegal = !f_rs_ok || !f_rt_ok;
            end
            5'd7: begin
                dec_rd = {2'b00, instr[6:0]};
            end
            5'd8: begin
                // beq: rt is a literal, not a register index, so it cannot be illegal
                dec_rd      = f_rd;
                dec_rs_val  = val_rs;
                dec_rt_val  = {{(DATA_W-9){1'b0}}, f_rt};
                dec_illegal = !f_rs_ok;
            end
            5'd9: begin
                // slr reads the register named by the rd field as its first operand
                dec_rd      = f_rd;
                dec_rs_val  = val_rd;
                dec_rt_val  = val_rt;
                dec_illegal = !f_rd_ok || !f_rt_ok;
            end
            5'd10: begin
                dec_rs_val = {{(DATA_W-10){1'b0}}, instr[9:0]};
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Pipeline register
    logic              out_valid_q, out_valid_d;
    logic [4:0]        opcode_q,    opcode_d;
    logic [8:0]        rd_q,        rd_d;
    logic [DATA_W-1:0] rs_val_q,    rs_val_d;
    logic [DATA_W-1:0] rt_val_q,    rt_val_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic              illegal_q,   illegal_d;
    logic              accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Load on accept, clear when the held bundle leaves with nothing behind it,
    // otherwise hold (stall or idle).
    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = dec_opcode;
            rd_d        = dec_rd;
            rs_val_d    = dec_rs_val;
            rt_val_d    = dec_rt_val;
            imm_d       = dec_imm;
            illegal_d   = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            opcode_d    = '0;
            rd_d        = '0;
            rs_val_d    = '0;
            rt_val_d    = '0;
            imm_d       = '0;
            illegal_d   = 1'b0;
        end
    end

    // Bundle storage; reset drops any pending bundle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            rd_q        <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign rs_val    = rs_val_q;
    assign rt_val    = rt_val_q;
    assign imm       = imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage (default parameters).
// The reference model keeps an architectural register array and a queue of
// decoded bundles that are owed to the consumer. A compare process checks the
// DUT against the model on every falling edge. Directed checks with
// hand-computed literals pin the expected values of the model.

module tb_decode_stage;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int BW     = 5 + 9 + 3 * DATA_W + 1;
`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              wb_en;
    logic [8:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        opcode;
    logic [8:0]        rd;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_stage #(.DATA_W(DATA_W), .NUM_REGS(NREGS)) dut (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .imm       (imm),
        .illegal   (illegal)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [BW-1:0]     exp_q [$];

    function automatic logic [DATA_W-1:0] m_read(input int idx, output bit bad);
        bad = 1'b0;
        if (idx >= NREGS) begin
            bad = 1'b1;
            return '0;
        end
        if (BYP && wb_en && (int'(wb_addr) < NREGS) && (int'(wb_addr) == idx))
            return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [BW-1:0] m_decode(input logic [31:0] i);
        int op  = int'(i[31:27]);
        int frd = int'(i[26:18]);
        int frs = int'(i[17:9]);
        int frt = int'(i[8:0]);
        int rdv = 0;
        logic [DATA_W-1:0] rs = '0;
        logic [DATA_W-1:0] rt = '0;
        logic [DATA_W-1:0] im = '0;
        bit ill = 1'b0;
        bit b1 = 1'b0;
        bit b2 = 1'b0;
        if (op == 0) begin
            rdv = 0;
        end else if (op >= 2 && op <= 5) begin
            rdv = frd; rs = m_read(frs, b1); rt = m_read(frt, b2); ill = b1 | b2;
        end else if (op == 1 || op == 6) begin
            rdv = frd; im = DATA_W'(i[17:0]);
        end else if (op == 7) begin
            rdv = int'(i[6:0]);
        end else if (op == 8) begin
            rdv = frd; rs = m_read(frs, b1); rt = DATA_W'(frt); ill = b1;
        end else if (op == 9) begin
            rdv = frd; rs = m_read(frd, b1); rt = m_read(frt, b2); ill = b1 | b2;
        end else if (op == 10) begin
            rs = DATA_W'(i[9:0]);
        end else begin
            ill = 1'b1;
        end
        return {5'(op), 9'(rdv), rs, rt, im, ill};
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        end else if (clk) begin
            bit have;
            bit acc;
            logic [BW-1:0] nb;
            have = (exp_q.size() != 0);
            acc  = in_valid && (!have || out_ready);
            nb   = m_decode(instr);
            if (have && out_ready) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(nb);
            if (wb_en && int'(wb_addr) < NREGS) m_regs[int'(wb_addr)] = wb_data;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [BW-1:0] act;
        act = {opcode, rd, rs_val, rt_val, imm, illegal};
        if (reset) begin
            check("rst_out_valid", 128'(out_valid), 128'd0);
            check("rst_in_ready", 128'(in_ready), 128'd1);
            check("rst_bundle", 128'(act), 128'd0);
        end else begin
            check("model_out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
            check("model_in_ready", 128'(in_ready), 128'((exp_q.size() == 0) || out_ready));
            if (exp_q.size() != 0) check("model_bundle", 128'(act), 128'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mk(input int op, input int f1, input int f2, input int f3);
        return {5'(op), 9'(f1), 9'(f2), 9'(f3)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wb_en = 1'b1; wb_addr = 9'(a); wb_data = DATA_W'(d);
        step();
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] i);
        in_valid = 1'b1; instr = i; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string nm, input logic [31:0] i, input int erd,
                            input int ers, input int ert, input int eimm, input int eill);
        send(i);
        check({nm, "_valid"}, 128'(out_valid), 128'd1);
        check({nm, "_rd"}, 128'(rd), 128'(erd));
        check({nm, "_rs"}, 128'(rs_val), 128'(ers));
        check({nm, "_rt"}, 128'(rt_val), 128'(ert));
        check({nm, "_imm"}, 128'(imm), 128'(eimm));
        check({nm, "_ill"}, 128'(illegal), 128'(eill));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        step();
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        step();
        reset = 1'b0;

        // basic arithmetic read
        wr(3, 5);
        wr(4, 7);
        send_chk("arith", mk(2, 1, 3, 4), 1, 5, 7, 0, 0);

        // same-cycle writeback and read of R3
        wb_en = 1'b1; wb_addr = 9'd3; wb_data = 32'd9;
        send(mk(2, 2, 3, 4));
        wb_en = 1'b0;
        check("bypass_rs", 128'(rs_val), BYP ? 128'd9 : 128'd5);

        // stall for three cycles while R3 is overwritten
        out_ready = 1'b0; in_valid = 1'b1; instr = mk(3, 6, 3, 4);
        wb_en = 1'b1; wb_addr = 9'd3; wb_data = 32'd11;
        for (int c = 0; c < 3; c++) begin
            step();
            wb_en = 1'b0;
            check("hold_in_ready", 128'(in_ready), 128'd0);
            check("hold_rd", 128'(rd), 128'd2);
            check("hold_rs", 128'(rs_val), BYP ? 128'd9 : 128'd5);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("after_hold_op", 128'(opcode), 128'd3);
        check("after_hold_rd", 128'(rd), 128'd6);
        check("after_hold_rs", 128'(rs_val), 128'd11);
        step();
        check("drain_valid", 128'(out_valid), 128'd0);

        // out-of-range index and undefined opcode
        send_chk("oor_rs", mk(2, 1, 40, 4), 1, 0, 7, 0, 1);
        send_chk("op15", {5'd15, 27'h5A5A5A5}, 0, 0, 0, 0, 1);
        check("op15_opcode", 128'(opcode), 128'd15);

        // out-of-range write must not alias onto R3
        wr(35, 32'hDEAD);
        send_chk("wr_ignored", mk(2, 0, 3, 3), 0, 11, 11, 0, 0);

        // immediate, branch and the remaining opcodes
        send_chk("lv_imm", {5'd1, 9'd5, 18'h3FFFF}, 5, 0, 0, 32'h3FFFF, 0);
        send_chk("b_target", {5'd7, 20'hFFFFF, 7'h55}, 32'h55, 0, 0, 0, 0);
        send_chk("beq", mk(8, 7, 4, 300), 7, 7, 300, 0, 0);
        send_chk("slr", mk(9, 4, 0, 3), 4, 7, 11, 0, 0);
        send_chk("slr_oor", mk(9, 33, 1, 1), 33, 0, 0, 0, 1);
        send_chk("gp", {5'd10, 17'h1FFFF, 10'h2AB}, 0, 32'h2AB, 0, 0, 0);
        send_chk("cp", {5'd6, 9'd9, 18'h12345}, 9, 0, 0, 32'h12345, 0);
        send_chk("nop", {5'd0, 27'h7FFFFFF}, 0, 0, 0, 0, 0);

        // mixed valid/ready pattern with writes, checked by the model
        for (int i = 0; i < 16; i++) begin
            in_valid  = (i % 3) != 2;
            out_ready = (i % 4) != 1;
            instr     = mk(2 + (i % 4), i, i % 6, (i + 1) % 6);
            wb_en     = (i % 2) == 0;
            wb_addr   = 9'(i % 6);
            wb_data   = DATA_W'(i * 3 + 1);
            step();
        end
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        step();

        // reset while a bundle is pending
        in_valid = 1'b1; instr = mk(2, 1, 3, 4); out_ready = 1'b0;
        wr(3, 77);
        in_valid = 1'b0;
        check("pre_reset_valid", 128'(out_valid), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'd0);
        check("async_rst_rd", 128'(rd), 128'd0);
        check("async_rst_rs", 128'(rs_val), 128'd0);
        check("async_rst_in_ready", 128'(in_ready), 128'd1);
        wb_en = 1'b1; wb_addr = 9'd3; wb_data = 32'd99;
        step();
        step();
        reset = 1'b0; wb_en = 1'b0;
        send_chk("post_reset", mk(2, 1, 3, 4), 1, 0, 0, 0, 0);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
